img_stream_tx: RTL and testbench

- Video stream transmitter: the source side of the vsync/href/gray pixel-stream interface that the filter blocks consume.
- Pulls 8-bit gray pixels from an upstream valid/ready source, such as a frame-buffer reader.
- Emits them with frame/line timing: vsync as the frame envelope, href as the line-active strobe.
- Feeds per_img_* inputs of downstream processing blocks; also serves as a bench stimulus source.

---
 rtl/img_stream_tx.sv | 137 +++++++++++++
 tb/tb_img_stream_tx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_tx.sv
// img_stream_tx: vsync/href/gray stream source pulling pixels from a valid/ready upstream.
// Optional build macro IMG_STREAM_TX_PATTERN_EN adds pattern_sel, a (x + y) test-pattern source.
module img_stream_tx #(
    parameter int IMG_H_DISP = 640,
    parameter int IMG_V_DISP = 480,
    parameter int H_BLANK    = 160,
    parameter int V_GAP      = 10,
    parameter int V_PRE      = 2,
    parameter int V_POST     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        continuous,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        post_img_vsync,
    output logic        post_img_href,
    output logic [7:0]  post_img_gray,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        underflow,
    input  logic        underflow_clr
`ifdef IMG_STREAM_TX_PATTERN_EN
    ,
    input  logic        pattern_sel
`endif
);
    localparam int H_TOTAL = IMG_H_DISP + H_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int V_MAX   = (IMG_V_DISP > V_GAP ? IMG_V_DISP : V_GAP) > (V_PRE > V_POST ? V_PRE : V_POST)
                           ? (IMG_V_DISP > V_GAP ? IMG_V_DISP : V_GAP) : (V_PRE > V_POST ? V_PRE : V_POST);
    localparam int VW      = $clog2(V_MAX + 1);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(IMG_H_DISP);
    localparam logic [VW-1:0] GAP_LAST  = VW'(V_GAP - 1);
    localparam logic [VW-1:0] PRE_LAST  = VW'(V_PRE > 0 ? V_PRE - 1 : 0);
    localparam logic [VW-1:0] ACT_LAST  = VW'(IMG_V_DISP - 1);
    localparam logic [VW-1:0] POST_LAST = VW'(V_POST > 0 ? V_POST - 1 : 0);

    typedef enum logic [2:0] {IDLE, GAP, PRE, ACTIVE, POST} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            start_pend, pend_nxt;
    logic            line_end, restart, frame_exit, gap_entry, act_slot, pat_q;
    logic [7:0]      pix_pat;

    // Next-state decode: each state lasts a whole number of lines; frame exit decides restart vs idle.
    always_comb begin
        line_end   = h_cnt == H_LAST;
        restart    = continuous | start_pend;
        frame_exit = 1'b0;
        state_nxt  = state;
        case (state)
            IDLE:    if (frame_start | restart) state_nxt = GAP;
            GAP:     if (line_end && v_cnt == GAP_LAST) state_nxt = (V_PRE > 0) ? PRE : ACTIVE;
            PRE:     if (line_end && v_cnt == PRE_LAST) state_nxt = ACTIVE;
            ACTIVE:  if (line_end && v_cnt == ACT_LAST) begin
                         if (V_POST > 0) state_nxt = POST;
                         else begin
                             frame_exit = 1'b1;
                             state_nxt  = restart ? GAP : IDLE;
                         end
                     end
            POST:    if (line_end && v_cnt == POST_LAST) begin
                         frame_exit = 1'b1;
                         state_nxt  = restart ? GAP : IDLE;
                     end
            default: state_nxt = IDLE;
        endcase
        gap_entry = state_nxt == GAP && state != GAP;
        pend_nxt  = gap_entry ? 1'b0 : (frame_start && state != IDLE) ? 1'b1 : start_pend;
        act_slot  = state == ACTIVE && h_cnt < H_ACT;
        pix_pat   = 8'(h_cnt) + 8'(v_cnt);
    end

    assign in_ready = act_slot & ~pat_q;
    assign busy     = state != IDLE;

    // State register and a single-deep pending start request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            start_pend <= pend_nxt;
        end
    end

    // Pixel and line counters restart at every state entry and sit at zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state_nxt != state || state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + 1'b1;
            v_cnt <= line_end ? v_cnt + 1'b1 : v_cnt;
        end
    end

`ifdef IMG_STREAM_TX_PATTERN_EN
    // Pattern mode is latched once per frame so a mid-frame toggle cannot tear the image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pat_q <= 1'b0;
        else if (gap_entry) pat_q <= pattern_sel;
    end
`else
    assign pat_q = 1'b0;
`endif

    // Registered stream outputs, status flags and completed-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_vsync <= 1'b0;
            post_img_href  <= 1'b0;
            post_img_gray  <= 8'd0;
            underflow      <= 1'b0;
            frame_done     <= 1'b0;
            frame_cnt      <= 16'd0;
        end else begin
            post_img_vsync <= state == PRE || state == ACTIVE || state == POST;
            post_img_href  <= act_slot;
            post_img_gray  <= !act_slot ? 8'd0 : pat_q ? pix_pat : in_valid ? in_data : 8'd0;
            underflow      <= (act_slot && !pat_q && !in_valid) ? 1'b1 : underflow_clr ? 1'b0 : underflow;
            frame_done     <= frame_exit;
            frame_cnt      <= frame_cnt + 16'(frame_exit);
        end
    end
endmodule

// File: tb/tb_img_stream_tx.sv
// tb_img_stream_tx: directed self-checking bench for img_stream_tx with a 4x3 image.
module tb_img_stream_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        continuous = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic        post_img_vsync, post_img_href, busy, frame_done, underflow;
    logic [7:0]  post_img_gray;
    logic [15:0] frame_cnt;
`ifdef IMG_STREAM_TX_PATTERN_EN
    logic        pattern_sel = 1'b0;
`endif

    int   errors = 0, checks = 0, exp_frames = 0;
    int   src_idx = 0, slot_idx = 0, drop_slot = -1;
    logic valid_en = 1'b1;

    int   pix[$], runs[$], gaps[$];
    int   vs_high, run, low_run, done_cnt, rdy_cnt, gray_bad;
    bit   seen_hi;

    img_stream_tx #(
        .IMG_H_DISP(4), .IMG_V_DISP(3), .H_BLANK(2), .V_GAP(1), .V_PRE(1), .V_POST(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .continuous(continuous),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .post_img_vsync(post_img_vsync), .post_img_href(post_img_href), .post_img_gray(post_img_gray),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .underflow(underflow), .underflow_clr(underflow_clr)
`ifdef IMG_STREAM_TX_PATTERN_EN
        , .pattern_sel(pattern_sel)
`endif
    );

    always #5 clk = ~clk;

    assign in_valid = valid_en && (slot_idx != drop_slot);
    assign in_data  = src_idx[7:0];

    always @(posedge clk) begin
        if (in_ready) slot_idx <= slot_idx + 1;
        if (in_ready && in_valid) src_idx <= src_idx + 1;
    end

    always @(negedge clk) begin
        if (post_img_vsync) vs_high++;
        if (post_img_href) begin
            pix.push_back(int'(post_img_gray));
            run++;
        end else begin
            if (run != 0) runs.push_back(run);
            run = 0;
            if (post_img_gray != 8'd0) gray_bad++;
        end
        if (post_img_vsync) begin
            if (seen_hi && low_run > 0) gaps.push_back(low_run);
            seen_hi = 1'b1;
            low_run = 0;
        end else low_run++;
        if (frame_done) done_cnt++;
        if (in_ready) rdy_cnt++;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon;
        pix.delete(); runs.delete(); gaps.delete();
        vs_high = 0; run = 0; low_run = 0; done_cnt = 0; rdy_cnt = 0; gray_bad = 0; seen_hi = 1'b0;
    endtask

    task automatic pulse_start;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        tick;
        while (busy && n < budget) begin
            tick;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
        end
        repeat (3) tick;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        checks++;
        if ({post_img_vsync, post_img_href, post_img_gray, busy, frame_done, underflow, in_ready} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0",
                     {post_img_vsync, post_img_href, post_img_gray, busy, frame_done, underflow, in_ready});
        end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt); end
        rst_n = 1'b1;
        repeat (3) tick;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_single_frame;
        int base = src_idx;
        clear_mon;
        pulse_start;
        wait_idle(100);
        exp_frames++;
        checks++;
        if (vs_high != 30) begin errors++; $display("FAIL single_vsync_len: got %0d, required 30", vs_high); end
        checks++;
        if (runs.size() != 3 || runs[0] != 4 || runs[1] != 4 || runs[2] != 4) begin
            errors++;
            $display("FAIL single_href_runs: got %0d runs (%0d,%0d,%0d), required 3 of 4",
                     runs.size(), runs[0], runs[1], runs[2]);
        end
        checks++;
        if (pix.size() != 12) begin errors++; $display("FAIL single_pix_count: got %0d, required 12", pix.size()); end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (pix[k] != ((base + k) & 255)) begin
                errors++;
                $display("FAIL single_pix[%0d]: got %0h, required %0h", k, pix[k], (base + k) & 255);
            end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL single_done: got %0d pulses, required 1", done_cnt); end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL single_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL single_underflow: got %b, required 0", underflow); end
        checks++;
        if (gray_bad != 0) begin errors++; $display("FAIL single_gray_blank: got %0d nonzero blank samples, required 0", gray_bad); end
    endtask

    task automatic test_underflow;
        int base = src_idx;
        int n = 0;
        clear_mon;
        drop_slot = slot_idx + 1;
        pulse_start;
        wait_idle(100);
        exp_frames++;
        checks++;
        if (pix[0] != (base & 255) || pix[1] != 0 || pix[2] != ((base + 1) & 255)) begin
            errors++;
            $display("FAIL uf_pixels: got %0h %0h %0h, required %0h 0 %0h", pix[0], pix[1], pix[2], base & 255, (base + 1) & 255);
        end
        checks++;
        if (runs.size() != 3 || runs[0] != 4) begin errors++; $display("FAIL uf_line_len: got %0d, required 4", runs[0]); end
        checks++;
        if (pix.size() != 12) begin errors++; $display("FAIL uf_pix_count: got %0d, required 12", pix.size()); end
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b, required 1", underflow); end
        underflow_clr = 1'b1;
        tick;
        underflow_clr = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b, required 0", underflow); end
        clear_mon;
        drop_slot = slot_idx + 5;
        pulse_start;
        while (!(in_ready && slot_idx == drop_slot) && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (!(in_ready && slot_idx == drop_slot)) begin errors++; $display("FAIL uf_slot_wait: slot %0d not reached, required %0d", slot_idx, drop_slot); end
        underflow_clr = 1'b1;
        tick;
        underflow_clr = 1'b0;
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins: got %b, required 1", underflow); end
        wait_idle(100);
        exp_frames++;
        drop_slot = -1;
        underflow_clr = 1'b1;
        tick;
        underflow_clr = 1'b0;
    endtask

    task automatic test_continuous;
        int n = 0;
        clear_mon;
        continuous = 1'b1;
        while (done_cnt < 2 && n < 200) begin
            tick;
            n++;
        end
        checks++;
        if (done_cnt != 2) begin errors++; $display("FAIL cont_wait: got %0d frames, required 2", done_cnt); end
        repeat (10) tick;
        continuous = 1'b0;
        wait_idle(200);
        exp_frames += 3;
        checks++;
        if (done_cnt != 3) begin errors++; $display("FAIL cont_done: got %0d, required 3", done_cnt); end
        checks++;
        if (gaps.size() != 2 || gaps[0] != 6 || gaps[1] != 6) begin
            errors++;
            $display("FAIL cont_gaps: got %0d gaps (%0d,%0d), required 2 of 6", gaps.size(), gaps[0], gaps[1]);
        end
        checks++;
        if (vs_high != 90) begin errors++; $display("FAIL cont_vsync: got %0d, required 90", vs_high); end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL cont_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_pending;
        int n = 0;
        clear_mon;
        pulse_start;
        while (runs.size() < 1 && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (runs.size() < 1) begin errors++; $display("FAIL pend_active_wait: got %0d lines, required 1", runs.size()); end
        pulse_start;
        tick;
        pulse_start;
        tick;
        pulse_start;
        wait_idle(300);
        exp_frames += 2;
        checks++;
        if (done_cnt != 2) begin errors++; $display("FAIL pend_done: got %0d, required 2", done_cnt); end
        checks++;
        if (vs_high != 60) begin errors++; $display("FAIL pend_vsync: got %0d, required 60", vs_high); end
        checks++;
        if (gaps.size() != 1 || gaps[0] != 6) begin errors++; $display("FAIL pend_gap: got %0d gaps (%0d), required 1 of 6", gaps.size(), gaps[0]); end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL pend_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        clear_mon;
        pulse_start;
        while (pix.size() < 6 && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (pix.size() != 6) begin errors++; $display("FAIL rmid_wait: got %0d pixels, required 6", pix.size()); end
        rst_n = 1'b0;
        #1;
        exp_frames = 0;
        checks++;
        if ({post_img_vsync, post_img_href, post_img_gray, busy, frame_done, underflow, in_ready} !== 14'd0) begin
            errors++;
            $display("FAIL rmid_outputs: got %b, required 0",
                     {post_img_vsync, post_img_href, post_img_gray, busy, frame_done, underflow, in_ready});
        end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rmid_frame_cnt: got %0d, required 0", frame_cnt); end
        repeat (2) tick;
        rst_n = 1'b1;
        clear_mon;
        repeat (20) tick;
        checks++;
        if (vs_high != 0 || done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_quiet: got vsync=%0d done=%0d busy=%b, required 0 0 0", vs_high, done_cnt, busy);
        end
        pulse_start;
        wait_idle(100);
        exp_frames++;
        checks++;
        if (frame_cnt !== 16'(exp_frames) || vs_high != 30) begin
            errors++;
            $display("FAIL rmid_recover: got cnt=%0d vsync=%0d, required %0d 30", frame_cnt, vs_high, exp_frames);
        end
    endtask

`ifdef IMG_STREAM_TX_PATTERN_EN
    task automatic test_pattern;
        clear_mon;
        valid_en = 1'b0;
        pattern_sel = 1'b1;
        pulse_start;
        pattern_sel = 1'b0;
        wait_idle(100);
        exp_frames++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pix[8 + k] != 2 + k) begin errors++; $display("FAIL pat_line2[%0d]: got %0h, required %0h", k, pix[8 + k], 2 + k); end
        end
        checks++;
        if (pix[0] != 0 || pix[3] != 3 || pix[4] != 1) begin errors++; $display("FAIL pat_lines01: got %0h %0h %0h, required 0 3 1", pix[0], pix[3], pix[4]); end
        checks++;
        if (rdy_cnt != 0) begin errors++; $display("FAIL pat_ready: got %0d ready cycles, required 0", rdy_cnt); end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL pat_underflow: got %b, required 0", underflow); end
        valid_en = 1'b1;
    endtask
`endif

    initial begin
        clear_mon;
        test_reset;
        test_single_frame;
        test_underflow;
        test_continuous;
        test_pending;
        test_reset_mid;
`ifdef IMG_STREAM_TX_PATTERN_EN
        test_pattern;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
